// File: rtl/jtcop_ba_arb.sv
// jtcop_ba_arb
// Four-bank SDRAM request arbiter. It places one command at a time on the
// single-port SDRAM controller channel and steers the controller strobes
// back to the bank that owns the outstanding command.
//
// Parameters
//   RR  1 = round-robin among banks, 0 = fixed priority (bank 0 highest)
//   AW  word address width
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ba0_addr..ba3_addr            per-bank word address
//   ba_rd, ba_wr                  bank read requests, bank-0 write request
//   ba0_din, ba0_din_m            bank-0 write data and byte mask (1 = masked)
//   ba_ack/ba_dst/ba_dok/ba_rdy   one-hot strobes back to the owning bank
//   downloading, prog_*           ROM download port (mask active low)
//   prog_ack, prog_rdy            download accept / complete strobes
//   sdram_req..sdram_mask         registered command to the controller
//   sdram_ack/dst/dok/rdy         controller strobes
module jtcop_ba_arb #(
    parameter int RR = 1,
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic [3:0]    ba_rd,
    input  logic          ba_wr,
    input  logic [15:0]   ba0_din,
    input  logic [1:0]    ba0_din_m,
    output logic [3:0]    ba_ack,
    output logic [3:0]    ba_dst,
    output logic [3:0]    ba_dok,
    output logic [3:0]    ba_rdy,
    input  logic          downloading,
    input  logic [AW-1:0] prog_addr,
    input  logic [1:0]    prog_ba,
    input  logic [15:0]   prog_data,
    input  logic [1:0]    prog_mask,
    input  logic          prog_we,
    input  logic          prog_rd,
    output logic          prog_ack,
    output logic          prog_rdy,
    output logic          sdram_req,
    output logic [1:0]    sdram_ba,
    output logic [AW-1:0] sdram_addr,
    output logic          sdram_we,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_mask,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic          sdram_dok,
    input  logic          sdram_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          state_r;
    logic [1:0]      owner_r;
    logic [1:0]      last_r;
    logic            prog_own_r;

    logic [3:0]      cand_s;
    logic [1:0]      pick_s;
    logic [AW-1:0]   pick_addr_s;
    logic            pick_wr_s;
    logic            ack_hit_s;
    logic            rdy_hit_s;
    logic            data_s;
    logic [3:0]      owner_oh_s;

    // Lowest requesting index wins.
    function automatic logic [1:0] pick_fixed(input logic [3:0] req);
        logic [1:0] res;
        if (req[0]) begin
            res = 2'd0;
        end else if (req[1]) begin
            res = 2'd1;
        end else if (req[2]) begin
            res = 2'd2;
        end else begin
            res = 2'd3;
        end
        return res;
    endfunction

    // First requesting index after the last grant, wrapping 3 -> 0.
    function automatic logic [1:0] pick_rr(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] res;
        logic [1:0] idx;
        logic       found;
        res   = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] sel);
        logic [3:0] res;
        case (sel)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Bank candidates; a bank-0 write counts as a bank-0 request.
    always_comb begin
        cand_s = {ba_rd[3:1], ba_rd[0] | ba_wr};
    end

    // Grant selection according to the arbitration policy.
    always_comb begin
        if (RR != 0) begin
            pick_s = pick_rr(cand_s, last_r);
        end else begin
            pick_s = pick_fixed(cand_s);
        end
    end

    // Address of the selected bank; write only possible on bank 0.
    always_comb begin
        case (pick_s)
            2'd0:    pick_addr_s = ba0_addr;
            2'd1:    pick_addr_s = ba1_addr;
            2'd2:    pick_addr_s = ba2_addr;
            2'd3:    pick_addr_s = ba3_addr;
            default: pick_addr_s = ba0_addr;
        endcase
        pick_wr_s = (pick_s == 2'd0) && ba_wr;
    end

    // Arbitration FSM with registered command fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            owner_r    <= 2'd0;
            last_r     <= 2'd3;
            prog_own_r <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_ba   <= 2'd0;
            sdram_addr <= {AW{1'b0}};
            sdram_we   <= 1'b0;
            sdram_din  <= 16'd0;
            sdram_mask <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (downloading) begin
                        if (prog_we || prog_rd) begin
                            prog_own_r <= 1'b1;
                            sdram_ba   <= prog_ba;
                            sdram_addr <= prog_addr;
                            sdram_we   <= prog_we;
                            sdram_din  <= prog_data;
                            sdram_mask <= ~prog_mask;
                            sdram_req  <= 1'b1;
                            state_r    <= ST_REQ;
                        end else begin
                            state_r    <= ST_IDLE;
                        end
                    end else if (|cand_s) begin
                        prog_own_r <= 1'b0;
                        owner_r    <= pick_s;
                        last_r     <= pick_s;
                        sdram_ba   <= pick_s;
                        sdram_addr <= pick_addr_s;
                        sdram_we   <= pick_wr_s;
                        sdram_din  <= pick_wr_s ? ba0_din : 16'd0;
                        sdram_mask <= pick_wr_s ? ba0_din_m : 2'd0;
                        sdram_req  <= 1'b1;
                        state_r    <= ST_REQ;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        // ack and rdy together finish the transaction at once
                        state_r   <= sdram_rdy ? ST_IDLE : ST_DATA;
                    end else begin
                        state_r   <= ST_REQ;
                    end
                end
                ST_DATA: begin
                    if (sdram_rdy) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                default: begin
                    sdram_req <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobe qualification: ack only in REQ, data strobes only in DATA,
    // rdy in DATA or alongside ack in REQ.
    always_comb begin
        ack_hit_s  = (state_r == ST_REQ) && sdram_ack;
        data_s     = (state_r == ST_DATA);
        rdy_hit_s  = (data_s || ack_hit_s) && sdram_rdy;
        owner_oh_s = one_hot(owner_r);
    end

    // Zero-latency steering of the controller strobes to the owner.
    always_comb begin
        if (prog_own_r) begin
            ba_ack   = 4'b0000;
            ba_dst   = 4'b0000;
            ba_dok   = 4'b0000;
            ba_rdy   = 4'b0000;
            prog_ack = ack_hit_s;
            prog_rdy = rdy_hit_s;
        end else begin
            ba_ack   = ack_hit_s ? owner_oh_s : 4'b0000;
            ba_dst   = (data_s && sdram_dst) ? owner_oh_s : 4'b0000;
            ba_dok   = (data_s && sdram_dok) ? owner_oh_s : 4'b0000;
            ba_rdy   = rdy_hit_s ? owner_oh_s : 4'b0000;
            prog_ack = 1'b0;
            prog_rdy = 1'b0;
        end
    end

endmodule

// File: doc/jtcop_ba_arb.md
# jtcop_ba_arb

Four-bank SDRAM request arbiter between the jtcop bank-slot logic and the single-port SDRAM controller. It serialises the per-bank read requests, the bank-0 write and the ROM-download write/read onto one command channel. It keeps exactly one transaction outstanding and routes the controller's ack/dst/dok/rdy strobes back to the requesting bank. During download only the programming port is served.

## Interface
Parameters:
- RR, 1, 1 = round-robin grant among banks; 0 = fixed priority (bank 0 highest, bank 3 lowest)
- AW, 22, per-bank word address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous assertion, active-high
- ba0_addr..ba3_addr  in  AW each  per-bank word address
- ba_rd  in  4  per-bank read request, level, held until ba_ack
- ba_wr  in  1  bank-0 write request, level, held until ba_ack[0]
- ba0_din  in  16  bank-0 write data
- ba0_din_m  in  2  bank-0 write byte mask, active-high masks the byte
- ba_ack  out  4  one-hot, one cycle: command accepted for that bank
- ba_dst  out  4  one-hot: first read beat on data_read
- ba_dok  out  4  one-hot: data_read valid for that bank
- ba_rdy  out  4  one-hot, one cycle: transaction complete
- downloading  in  1  ROM download active
- prog_addr  in  AW  download word address
- prog_ba  in  2  download bank
- prog_data  in  16  download data
- prog_mask  in  2  download byte mask, active low
- prog_we, prog_rd  in  1  download write/read request, level, held until prog_ack
- prog_ack, prog_rdy  out  1  download accept and complete strobes
- sdram_req  out  1  command request to controller
- sdram_ba  out  2  command bank
- sdram_addr  out  AW  command address
- sdram_we  out  1  1 = write
- sdram_din  out  16  write data
- sdram_mask  out  2  write mask, active-high
- sdram_ack, sdram_dst, sdram_dok, sdram_rdy  in  1  controller strobes

## Operation
- States: IDLE, REQ, DATA.
- IDLE:
  - Sample the candidates.
  - If downloading=1, the only candidate is prog_we|prog_rd.
  - Otherwise the candidates are bank0 = ba_rd[0]|ba_wr and bank k = ba_rd[k] for k = 1..3.
  - With no candidate, stay in IDLE.
  - Otherwise register the owner, sdram_ba, sdram_addr, sdram_we, sdram_din and sdram_mask, then go to REQ.
- Bank-0 write takes precedence over a bank-0 read when both are high. Write: sdram_we=1, din=ba0_din, mask=ba0_din_m.
- Download: sdram_ba=prog_ba, sdram_we=prog_we, mask=~prog_mask.
- Grant order:
  - RR=1: first requesting bank after the last-granted bank, cyclic 0→1→2→3→0. The last-granted pointer resets to 3, so bank 0 wins the first tie.
  - RR=0: lowest index wins.
- REQ:
  - sdram_req=1, with command fields held stable.
  - On sdram_ack: pulse ba_ack[owner] (or prog_ack), drop sdram_req, go to DATA.
- DATA:
  - ba_dst, ba_dok and ba_rdy are the controller strobes decoded to the owner.
  - Writes also terminate on sdram_rdy.
  - On sdram_rdy, pulse ba_rdy[owner] (or prog_rdy) and return to IDLE.
- Strobes are never decoded to a non-owner, and never decoded in IDLE or REQ, except that ack is decoded in REQ only.
- A change of downloading during REQ/DATA does not abort the transaction. The new mode applies from the next IDLE.
- Deasserting a request before its ack is a protocol error. The registered command still completes and its strobes are still delivered.

## Timing
- Reset values: sdram_req=0; ba_ack/ba_dst/ba_dok/ba_rdy=0; prog_ack=prog_rdy=0; sdram_we=0; sdram_addr=0; sdram_ba=0; sdram_din=0; sdram_mask=0; state IDLE. Reset mid-transaction drops sdram_req immediately.
- Request high at edge N while in IDLE → sdram_req=1 from edge N+1 (registered).
- ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack and prog_rdy are combinational from the controller strobes AND owner/state. They are zero-latency, same cycle as the controller strobe.
- After sdram_rdy at edge M, the next grant can assert sdram_req at M+2 at the earliest (IDLE sample at M+1).
- sdram_ack and sdram_rdy in the same cycle in REQ: ack then rdy both pulse that cycle, and the FSM goes to IDLE.
- Outputs are stable from sdram_req rise until sdram_ack.

## Test plan
- Single read: ba_rd=4'b0100, ba2_addr=22'h10_0040, controller acks 2 cycles after req → sdram_ba=2, addr=22'h10_0040, we=0, ba_ack=4'b0100; dst/dok/rdy route only to bank 2.
- Round robin: ba_rd=4'b1111 held, each request dropped after its ack → grant order 0,1,2,3,0.
- Fixed priority: same stimulus with RR=0 → bank 0 repeatedly.
- Bank-0 write vs read: ba_wr=1 and ba_rd[0]=1, ba0_din=16'hA55A, mask=2'b10 → sdram_we=1, din=16'hA55A, mask=2'b10; ba_rdy[0] on sdram_rdy.
- Download: downloading=1, prog_we=1, prog_ba=3, prog_addr=22'h4_0010, prog_mask=2'b01, with ba_rd=4'b0001 also high → bank 0 is never acked; sdram_ba=3, mask=2'b10, prog_ack then prog_rdy.
- Async reset asserted in DATA with sdram_req history → all outputs 0 in the same cycle; after release, a pending ba_rd[1] is granted with req 1 cycle after the first sampling edge.
